// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM states, requester ids and the round-robin pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_AUX  = 1'b1;

    // On a tie the requester that did not win last time gets the port.
    function automatic req_id_t rr_winner(input logic r0, input logic r1, input req_id_t last);
        req_id_t w;
        if (r0 && r1) begin
            w = (last == REQ_CORE) ? REQ_AUX : REQ_CORE;
        end else if (r1) begin
            w = REQ_AUX;
        end else begin
            w = REQ_CORE;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter; slave = arbiter view, master = the
// requesters plus memory that surround it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_W-1:0]     addr0;
    logic [ADDR_W-1:0]     addr1;
    logic [DATA_W-1:0]     wdata0;
    logic [DATA_W-1:0]     wdata1;
    logic [DATA_W/8-1:0]   wstrb0;
    logic [DATA_W/8-1:0]   wstrb1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic                  err0;
    logic                  err1;
    logic [DATA_W-1:0]     rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
        input  mem_rdata, mem_ack,
        output gnt0, gnt1, done0, done1, err0, err1, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
        output mem_rdata, mem_ack,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: combinational winner, last_gnt register updated on each grant.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req0,
    input  logic    req1,
    input  logic    update,
    output req_id_t winner
);

    req_id_t last_gnt;

    assign winner = rr_winner(req0, req1, last_gnt);

    // Reset to AUX so the first tie goes to the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= REQ_AUX;
        end else if (update) begin
            last_gnt <= winner;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between core (0) and aux (1); gnt 1 cycle after req, done 1 cycle after ack.
// One transaction in flight, requesters stall until done; MEM_ARB_TIMEOUT_EN adds a BUSY abort timer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state;
    req_id_t    winner;
    req_id_t    cur_id;
    logic       take;

    assign take = (state == IDLE) && (bus.req0 || bus.req1);

    rr_pick2 u_pick (
        .clk    (clk),
        .reset  (reset),
        .req0   (bus.req0),
        .req1   (bus.req1),
        .update (take),
        .winner (winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign bus.err0       = 1'b0;
    assign bus.err1       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_id        <= REQ_CORE;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.rdata     <= {DATA_W{1'b0}};
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_wstrb <= {(DATA_W/8){1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
            cnt           <= '0;
`endif
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state         <= BUSY;
                        cur_id        <= winner;
                        bus.gnt0      <= (winner == REQ_CORE);
                        bus.gnt1      <= (winner == REQ_AUX);
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= (winner == REQ_AUX) ? bus.we1    : bus.we0;
                        bus.mem_addr  <= (winner == REQ_AUX) ? bus.addr1  : bus.addr0;
                        bus.mem_wdata <= (winner == REQ_AUX) ? bus.wdata1 : bus.wdata0;
                        bus.mem_wstrb <= (winner == REQ_AUX) ? bus.wstrb1 : bus.wstrb0;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt           <= '0;
`endif
                    end
                end
                BUSY: begin
                    // An ack in the same cycle as the limit completes normally.
                    if (bus.mem_ack) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        bus.done0   <= (cur_id == REQ_CORE);
                        bus.done1   <= (cur_id == REQ_AUX);
                        bus.rdata   <= bus.mem_we ? {DATA_W{1'b0}} : bus.mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        bus.err0    <= 1'b0;
                        bus.err1    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        bus.done0   <= (cur_id == REQ_CORE);
                        bus.done1   <= (cur_id == REQ_AUX);
                        bus.rdata   <= {DATA_W{1'b0}};
                        bus.err0    <= (cur_id == REQ_CORE);
                        bus.err1    <= (cur_id == REQ_AUX);
                    end else begin
                        cnt         <= cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus hand-written arbitration,
// reset-in-flight and (with MEM_ARB_TIMEOUT_EN) timeout sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          k;
        logic [31:0] mrdata;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t tbl [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0      = 1'b0;  bus.req1   = 1'b0;
        bus.we0       = 1'b0;  bus.we1    = 1'b0;
        bus.addr0     = '0;    bus.addr1  = '0;
        bus.wdata0    = '0;    bus.wdata1 = '0;
        bus.wstrb0    = '0;    bus.wstrb1 = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic run_txn(input txn_t t);
        if (t.id == REQ_CORE) begin
            bus.req0 = 1'b1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata; bus.wstrb0 = t.wstrb;
        end else begin
            bus.req1 = 1'b1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata; bus.wstrb1 = t.wstrb;
        end
        step();
        chk("gnt", {bus.gnt0, bus.gnt1}, t.id ? 2'b01 : 2'b10);
        chk("mem_req_on", bus.mem_req, 1'b1);
        chk("mem_addr", bus.mem_addr, t.addr);
        chk("mem_wdata", bus.mem_wdata, t.wdata);
        chk("mem_we_strb", {bus.mem_we, bus.mem_wstrb}, {t.we, t.wstrb});
        // Requester fields change after grant; the memory side must not follow.
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = ~t.we; bus.we1 = ~t.we;
        bus.addr0 = ~t.addr; bus.addr1 = ~t.addr;
        bus.wdata0 = ~t.wdata; bus.wdata1 = ~t.wdata;
        bus.wstrb0 = ~t.wstrb; bus.wstrb1 = ~t.wstrb;
        for (int i = 1; i < t.k; i++) begin
            step();
            chk("busy_hold", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_req}, 5'b00001);
            chk("busy_fields", {bus.mem_we, bus.mem_wstrb, bus.mem_addr}, {t.we, t.wstrb, t.addr});
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = t.mrdata;
        step();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hBAD0_BAD0;
        chk("done", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_req}, t.id ? 5'b00010 : 5'b00100);
        chk("rdata", bus.rdata, t.exp_rdata);
        chk("err", {bus.err0, bus.err1}, 2'b00);
        step();
        chk("done_pulse", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_req}, 5'b00000);
        chk("rdata_hold", bus.rdata, t.exp_rdata);
    endtask

    initial begin
        logic exp_id;
        int   cyc;

        idle_inputs();
        bus.req0  = 1'b1;
        bus.addr0 = 32'h100;
        reset     = 1'b1;
        step();
        step();
        chk("rst_ctrl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_req, bus.mem_we}, 8'h00);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", {bus.mem_wdata, bus.mem_wstrb}, 36'h0);
        reset = 1'b0;

        //           id        we    addr          wdata         strb  k  mem_rdata     exp_rdata
        tbl[0] = '{REQ_CORE, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1] = '{REQ_AUX,  1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'h3, 2, 32'h1234_5678, 32'h0};
        tbl[2] = '{REQ_CORE, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'hF, 1, 32'h5555_AAAA, 32'h0};
        tbl[3] = '{REQ_AUX,  1'b0, 32'h0000_0208, 32'h0,        4'h0, 4, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[4] = '{REQ_AUX,  1'b0, 32'h0000_0000, 32'h0,        4'h0, 1, 32'h0000_0001, 32'h0000_0001};
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i]);
        end

        // Stray ack while idle.
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_ack = 1'b0;
        chk("idle_ack_ignored", {bus.done0, bus.done1, bus.mem_req}, 3'b000);
        chk("idle_ack_rdata", bus.rdata, 32'h0000_0001);

        // Reset while BUSY: mem_req drops without a clock edge, nothing completes.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h500;
        step();
        chk("pre_rst_gnt1", {bus.gnt1, bus.mem_req}, 2'b11);
        bus.req1 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem_req", {bus.mem_req, bus.gnt1}, 2'b00);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_done_after_rst", {bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_req}, 5'b00000);
        end

        // Both requesters held high: grants alternate starting with the core.
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.we0 = 1'b0;  bus.we1 = 1'b0;
        bus.addr0 = 32'h300; bus.addr1 = 32'h400;
        for (int t = 0; t < 4; t++) begin
            exp_id = t[0];
            step();
            chk("rr_gnt", {bus.gnt0, bus.gnt1}, exp_id ? 2'b01 : 2'b10);
            chk("rr_addr", bus.mem_addr, exp_id ? 32'h400 : 32'h300);
            step();
            chk("rr_busy_nognt", {bus.gnt0, bus.gnt1}, 2'b00);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + 32'(t);
            step();
            bus.mem_ack = 1'b0;
            chk("rr_done", {bus.done0, bus.done1, bus.gnt0, bus.gnt1}, exp_id ? 4'b0100 : 4'b1000);
            chk("rr_rdata", bus.rdata, 32'h1000 + 32'(t));
            step();
            chk("rr_done_nognt", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 4'b0000);
        end
        idle_inputs();
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: abort after 8 BUSY cycles with err0 and zero rdata.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h600;
        step();
        chk("to_gnt", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        cyc = 0;
        while (!bus.done0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("to_cycles", cyc, 8);
        chk("to_err", {bus.done0, bus.err0, bus.err1}, 3'b110);
        chk("to_rdata", bus.rdata, 32'h0);
        step();

        // Ack in the 8th BUSY cycle beats the timeout.
        bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
        end
        chk("to_still_busy", {bus.done0, bus.mem_req}, 2'b01);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_CAFE;
        step();
        bus.mem_ack = 1'b0;
        chk("to_ack_wins", {bus.done0, bus.err0}, 2'b10);
        chk("to_ack_rdata", bus.rdata, 32'h0BAD_CAFE);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
